// File: rtl/rc_pkg.sv
// Shared reservoir-computing types, sizes and helpers.
// Used by the readout, the reservoir and the weight trainer.
package rc_pkg;

  localparam int N_NEURONS  = 20;
  localparam int DATA_W     = 16;
  localparam int DATA_FRAC  = 8;
  localparam int WEIGHT_W   = 8;
  localparam int WEIGHT_FRAC = 6;
  localparam int ADDR_W     = 5;
  localparam int PROD_W     = 32;
  localparam int MU_SHIFT   = 20;

  localparam logic [15:0] ALT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERR,
    ST_UPDATE,
    ST_DONE
  } trainer_state_t;

  // Fibonacci x^16+x^14+x^13+x^11+1, left shift.
  function automatic logic [15:0] lfsr16_next(
    input logic [15:0] s
  );
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic signed [15:0] sat16(
    input logic signed [16:0] v
  );
    if (v > 17'sd32767)
      return 16'sh7FFF;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

  function automatic logic signed [7:0] sat8(
    input logic signed [PROD_W:0] v
  );
    if (v > 33'sd127)
      return 8'sh7F;
    else if (v < -33'sd128)
      return 8'sh80;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/rc_lfsr16.sv
// 16-bit Fibonacci LFSR with seed load and advance enable.
// A zero seed is replaced so the register never locks up.
module rc_lfsr16
  import rc_pkg::*;
#(
  parameter logic [15:0] P_ALT_SEED = ALT_SEED
) (
  input  logic        clk,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_en,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // Load seed on reset, otherwise step when enabled.
  always_ff @(posedge clk) begin
    if (i_load)
      r_state <= (i_seed == 16'h0000) ? P_ALT_SEED : i_seed;
    else if (i_en)
      r_state <= lfsr16_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/readout_weight_trainer.sv
// Owns the readout weights: LFSR init after reset,
// then one LMS step per accepted training sample.
module readout_weight_trainer
  import rc_pkg::*;
#(
  parameter int          N_NEURONS = rc_pkg::N_NEURONS,
  parameter int          MU_SHIFT  = rc_pkg::MU_SHIFT,
  parameter logic [15:0] ALT_SEED  = rc_pkg::ALT_SEED
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        training,
  input  logic [15:0]                 seed,
  input  logic [DATA_W*N_NEURONS-1:0] x_flat,
  input  logic [DATA_W-1:0]           y_target,
  input  logic [DATA_W-1:0]           y_out,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic                        w_we,
  output logic [ADDR_W-1:0]           w_addr,
  output logic [WEIGHT_W-1:0]         w_data,
  output logic                        update_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX =
    ADDR_W'(N_NEURONS - 1);

  trainer_state_t r_state;
  logic [ADDR_W-1:0] r_idx;
  logic signed [WEIGHT_W-1:0] r_w [N_NEURONS];

  logic [DATA_W*N_NEURONS-1:0] r_x;
  logic signed [DATA_W-1:0] r_yt;
  logic signed [DATA_W-1:0] r_yo;
  logic signed [DATA_W-1:0] r_err;

  logic r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WEIGHT_W-1:0] r_data;
  logic r_ready;
  logic r_done;

  logic [15:0] w_lfsr_state;
  logic [15:0] w_lfsr_next;
  logic w_lfsr_en;

  logic signed [DATA_W:0] w_diff;
  logic signed [DATA_W-1:0] w_err_now;
  logic signed [DATA_W-1:0] w_err_use;
  logic signed [DATA_W-1:0] w_xi;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_delta;
  logic signed [WEIGHT_W-1:0] w_wi;
  logic signed [PROD_W:0] w_sum;
  logic signed [WEIGHT_W-1:0] w_wnew;
  logic w_accept;

  assign w_lfsr_en = (r_state == ST_INIT) && !rst;
  assign w_lfsr_next = lfsr16_next(w_lfsr_state);

  rc_lfsr16 #(
    .P_ALT_SEED (ALT_SEED)
  ) u_lfsr (
    .clk     (clk),
    .i_load  (rst),
    .i_seed  (seed),
    .i_en    (w_lfsr_en),
    .o_state (w_lfsr_state)
  );

  // Error is formed at 17 bits so the clamp sees true overflow.
  assign w_diff = {r_yt[DATA_W-1], r_yt}
                - {r_yo[DATA_W-1], r_yo};
  assign w_err_now = sat16(w_diff);

  // Neuron 0 is updated in the ERR cycle, before r_err lands.
  assign w_err_use = (r_state == ST_ERR) ? w_err_now : r_err;

  assign w_xi = r_x[DATA_W*int'(r_idx) +: DATA_W];

  // The one multiplier, shared by all neurons in turn.
  assign w_prod =
    $signed({{(PROD_W-DATA_W){w_err_use[DATA_W-1]}}, w_err_use})
  * $signed({{(PROD_W-DATA_W){w_xi[DATA_W-1]}}, w_xi});

  assign w_delta = w_prod >>> MU_SHIFT;

  assign w_wi = r_w[r_idx];
  assign w_sum = {w_delta[PROD_W-1], w_delta}
               + {{(PROD_W+1-WEIGHT_W){w_wi[WEIGHT_W-1]}}, w_wi};
  assign w_wnew = sat8(w_sum);

  assign w_accept = sample_valid && r_ready;

  // Trainer FSM with registered weight-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_x     <= '0;
      r_yt    <= '0;
      r_yo    <= '0;
      r_err   <= '0;
      for (int i = 0; i < N_NEURONS; i++)
        r_w[i] <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_w[r_idx] <= w_lfsr_next[WEIGHT_W-1:0];
          r_we    <= 1'b1;
          r_addr  <= r_idx;
          r_data  <= w_lfsr_next[WEIGHT_W-1:0];
          r_ready <= 1'b0;
          r_done  <= 1'b0;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_IDLE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          if (w_accept) begin
            r_x  <= x_flat;
            r_yt <= y_target;
            r_yo <= y_out;
            if (training) begin
              r_ready <= 1'b0;
              r_idx   <= '0;
              r_state <= ST_ERR;
            end
          end
        end
        ST_ERR, ST_UPDATE: begin
          if (r_state == ST_ERR)
            r_err <= w_err_now;
          r_w[r_idx] <= w_wnew;
          r_we   <= 1'b1;
          r_addr <= r_idx;
          r_data <= w_wnew;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_UPDATE;
          end
        end
        ST_DONE: begin
          r_we    <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_INIT;
          r_idx   <= '0;
        end
      endcase
    end
  end

  assign sample_ready = r_ready;
  assign w_we         = r_we;
  assign w_addr       = r_addr;
  assign w_data       = r_data;
  assign update_done  = r_done;

endmodule

// File: tb/tb_readout_weight_trainer.sv
// Directed bench for readout_weight_trainer.
// Tracks expected weights and checks every port write.
module tb_readout_weight_trainer;

  localparam int N = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic training = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic [16*N-1:0] x_flat = '0;
  logic [15:0] y_target = '0;
  logic [15:0] y_out = '0;
  logic sample_valid = 1'b0;
  logic sample_ready;
  logic w_we;
  logic [4:0] w_addr;
  logic [7:0] w_data;
  logic update_done;

  int n_chk = 0;
  int n_pass = 0;
  int m_w[N];
  int m_x[N];
  logic [15:0] m_lfsr;

  readout_weight_trainer dut (
    .clk          (clk),
    .rst          (rst),
    .training     (training),
    .seed         (seed),
    .x_flat       (x_flat),
    .y_target     (y_target),
    .y_out        (y_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .w_we         (w_we),
    .w_addr       (w_addr),
    .w_data       (w_data),
    .update_done  (update_done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int s16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic int wd();
    logic signed [7:0] t;
    t = w_data;
    return int'(t);
  endfunction

  task automatic do_reset(input logic [15:0] s, input logic [15:0] ms);
    logic signed [7:0] b;
    rst = 1'b1;
    seed = s;
    sample_valid = 1'b0;
    @(negedge clk);
    chk("rst_we", w_we, 0);
    chk("rst_rdy", sample_ready, 0);
    chk("rst_done", update_done, 0);
    chk("rst_addr", w_addr, 0);
    chk("rst_data", w_data, 0);
    rst = 1'b0;
    seed = 16'h5A5A;
    m_lfsr = ms;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      m_lfsr = {m_lfsr[14:0],
                m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      b = m_lfsr[7:0];
      m_w[k] = int'(b);
      chk("init_we", w_we, 1);
      chk("init_addr", w_addr, k);
      chk("init_data", wd(), m_w[k]);
    end
    @(negedge clk);
    chk("init_end_we", w_we, 0);
    chk("init_end_rdy", sample_ready, 1);
  endtask

  task automatic run_sample(input int yt, input int yo,
                            input bit tr, input int stop_at);
    int waited;
    int e, p, d, nw;
    waited = 0;
    while (!sample_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!sample_ready) begin
      chk("rdy_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < N; i++)
      x_flat[16*i +: 16] = m_x[i][15:0];
    y_target = yt[15:0];
    y_out = yo[15:0];
    training = tr;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    training = 1'b0;
    y_target = 16'h1234;
    y_out = 16'hBEEF;
    x_flat = '1;
    if (!tr) begin
      for (int c = 0; c < 24; c++) begin
        chk("drop_we", w_we, 0);
        chk("drop_done", update_done, 0);
        chk("drop_rdy", sample_ready, 1);
        @(negedge clk);
      end
      return;
    end
    chk("err_we", w_we, 0);
    chk("err_rdy", sample_ready, 0);
    e = clamp(s16(yt) - s16(yo), -32768, 32767);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      p = e * s16(m_x[k]);
      d = p >>> 20;
      nw = clamp(m_w[k] + d, -128, 127);
      chk("upd_we", w_we, 1);
      chk("upd_addr", w_addr, k);
      chk("upd_data", wd(), nw);
      chk("upd_done_lo", update_done, 0);
      m_w[k] = nw;
      if (k == stop_at) return;
    end
    @(negedge clk);
    chk("done_pulse", update_done, 1);
    chk("done_we", w_we, 0);
    chk("done_rdy", sample_ready, 0);
    @(negedge clk);
    chk("done_clear", update_done, 0);
    chk("b2b_rdy", sample_ready, 1);
  endtask

  task automatic clear_x();
    for (int i = 0; i < N; i++) m_x[i] = 0;
  endtask

  initial begin
    do_reset(16'hACE1, 16'hACE1);
    do_reset(16'h0000, 16'hACE1);

    for (int i = 0; i < N; i++) m_x[i] = i * 291;
    run_sample('h0100, 'h0100, 1'b1, -1);

    do_reset(16'h803F, 16'h803F);
    chk("w0_is_127", m_w[0], 127);
    clear_x();
    m_x[0] = 'h7FFF;
    m_x[1] = 'h4000;
    run_sample('h7FFF, 'h8000, 1'b1, -1);
    m_x[0] = 'h8000;
    run_sample('h7FFF, 'h0000, 1'b1, -1);
    chk("w0_is_m128", m_w[0], -128);

    clear_x();
    m_x[3] = 'h1000;
    run_sample('h0100, 'h0000, 1'b1, -1);
    clear_x();
    m_x[3] = 'h0001;
    m_x[5] = 'h7FFF;
    run_sample('h0000, 'h0100, 1'b1, -1);
    clear_x();
    m_x[2] = 'h0020;
    run_sample('h8000, 'h7FFF, 1'b1, -1);

    m_x[3] = 'h1000;
    run_sample('h0100, 'h0000, 1'b0, -1);
    run_sample('h0100, 'h0000, 1'b1, 7);
    do_reset(16'hACE1, 16'hACE1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
